// File: rtl/conv_mac_pkg.sv
// Shared helpers for the convolution MAC array: ceil-log2, adder-tree
// depth / pipeline latency derivation and operand packing offsets.
package conv_mac_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Adder-tree depth for a FILTER_SIZE x FILTER_SIZE kernel.
  function automatic int unsigned tree_depth(input int unsigned fs);
    return clog2(fs * fs);
  endfunction

  // Multiply stage + tree stages + accumulate/output stage.
  function automatic int unsigned latency(input int unsigned fs);
    return tree_depth(fs) + 2;
  endfunction

  // Live node count at tree level l when level 0 holds n products.
  function automatic int unsigned nodes_at(input int unsigned n, input int unsigned l);
    return (n + (1 << l) - 1) >> l;
  endfunction

  // LSB of window tap j.
  function automatic int unsigned win_lsb(input int unsigned j, input int unsigned dw);
    return j * dw;
  endfunction

  // LSB of weight for channel c, tap j.
  function automatic int unsigned wt_lsb(input int unsigned c, input int unsigned j,
                                         input int unsigned n, input int unsigned dw);
    return (c * n + j) * dw;
  endfunction

endpackage

// File: rtl/conv_mac_lane.sv
// One output channel: registered signed products followed by a registered
// binary adder tree. Every register advances only while en is high.
module conv_mac_lane
  import conv_mac_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned FILTER_SIZE = 3,
  localparam int unsigned N  = FILTER_SIZE * FILTER_SIZE,
  localparam int unsigned D  = tree_depth(FILTER_SIZE),
  localparam int unsigned PW = 2 * DATA_WIDTH,
  localparam int unsigned SW = PW + D
)(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [N*DATA_WIDTH-1:0]      window,
  input  logic [N*DATA_WIDTH-1:0]      weights,
  output logic signed [SW-1:0]         tree_sum
);

  // Rows are 2N wide so the pair index 2k+1 never leaves the array;
  // slots beyond the live node count stay zero.
  logic signed [SW-1:0] lvl [0:D][0:2*N-1];
  logic signed [SW-1:0] nxt [0:D][0:2*N-1];

  // Next-state for products (level 0) and each tree level; an odd last node
  // is passed through so every tap sees exactly D stages.
  always_comb begin
    for (int unsigned l = 0; l <= D; l++)
      for (int unsigned k = 0; k < 2 * N; k++)
        nxt[l][k] = '0;
    for (int unsigned j = 0; j < N; j++)
      nxt[0][j] = SW'(PW'($signed(window[win_lsb(j, DATA_WIDTH) +: DATA_WIDTH])) *
                      PW'($signed(weights[win_lsb(j, DATA_WIDTH) +: DATA_WIDTH])));
    for (int unsigned l = 1; l <= D; l++)
      for (int unsigned k = 0; k < N; k++) begin
        if (2 * k + 1 < nodes_at(N, l - 1))
          nxt[l][k] = lvl[l-1][2*k] + lvl[l-1][2*k+1];
        else if (2 * k < nodes_at(N, l - 1))
          nxt[l][k] = lvl[l-1][2*k];
      end
  end

  // Pipeline registers for all levels, frozen during stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned l = 0; l <= D; l++)
        for (int unsigned k = 0; k < 2 * N; k++)
          lvl[l][k] <= '0;
    end else if (en) begin
      for (int unsigned l = 0; l <= D; l++)
        for (int unsigned k = 0; k < 2 * N; k++)
          lvl[l][k] <= nxt[l][k];
    end
  end

  assign tree_sum = lvl[D][0];

endmodule

// File: rtl/conv_mac_array.sv
// Multi-channel convolution MAC: per-channel product/adder-tree lanes, a
// framing FSM, per-channel frame accumulators and a valid/ready output.
// Optional build macro: CONV_MAC_SAT_EN (saturating accumulation).
module conv_mac_array
  import conv_mac_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned FILTER_SIZE = 3,
  parameter int unsigned NUM_OC      = 4,
  parameter int unsigned ACCUM_WIDTH = 32
)(
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic                                              i_valid,
  output logic                                              i_ready,
  input  logic                                              i_first,
  input  logic                                              i_last,
  input  logic [FILTER_SIZE*FILTER_SIZE*DATA_WIDTH-1:0]     i_window,
  input  logic [NUM_OC*FILTER_SIZE*FILTER_SIZE*DATA_WIDTH-1:0] i_weights,
  output logic                                              o_valid,
  input  logic                                              o_ready,
  output logic [NUM_OC*ACCUM_WIDTH-1:0]                     o_sum,
  output logic                                              o_proto_err
);

  localparam int unsigned N  = FILTER_SIZE * FILTER_SIZE;
  localparam int unsigned D  = tree_depth(FILTER_SIZE);
  localparam int unsigned SW = 2 * DATA_WIDTH + D;
  localparam int unsigned TW = N * DATA_WIDTH;
  localparam int unsigned AW = ACCUM_WIDTH;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ACCUM = 1'b1;

  logic       stall;
  logic       lane_en;
  logic       accept;
  logic       beat_ok;
  logic       err_hit;
  logic [0:0] state;
  logic [0:0] state_nxt;

  logic v_pipe [0:D];
  logic f_pipe [0:D];
  logic l_pipe [0:D];

  logic signed [SW-1:0] tree    [NUM_OC];
  logic signed [AW-1:0] ext     [NUM_OC];
  logic signed [AW-1:0] acc     [NUM_OC];
  logic signed [AW-1:0] acc_nxt [NUM_OC];
  logic [NUM_OC*AW-1:0] sum_nxt;
`ifdef CONV_MAC_SAT_EN
  logic signed [AW:0]   wide    [NUM_OC];
`endif

  assign stall   = o_valid && !o_ready;
  assign lane_en = !stall;
  assign i_ready = !stall;
  assign accept  = i_valid && i_ready;

  // Beat classification: drop non-first beats in IDLE, restart on a first
  // beat while a frame is open.
  always_comb begin
    beat_ok   = accept && (i_first || state == ST_ACCUM);
    err_hit   = accept && ((state == ST_IDLE && !i_first) || (state == ST_ACCUM && i_first));
    state_nxt = state;
    if (accept) begin
      if (i_first)
        state_nxt = i_last ? ST_IDLE : ST_ACCUM;
      else if (state == ST_ACCUM && i_last)
        state_nxt = ST_IDLE;
    end
  end

  // Framing FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Sticky framing-error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       o_proto_err <= 1'b0;
    else if (err_hit) o_proto_err <= 1'b1;
  end

  // Beat-control delay line tracking the lanes' multiply + tree stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s <= D; s++) begin
        v_pipe[s] <= 1'b0;
        f_pipe[s] <= 1'b0;
        l_pipe[s] <= 1'b0;
      end
    end else if (!stall) begin
      v_pipe[0] <= beat_ok;
      f_pipe[0] <= i_first;
      l_pipe[0] <= i_last;
      for (int unsigned s = 1; s <= D; s++) begin
        v_pipe[s] <= v_pipe[s-1];
        f_pipe[s] <= f_pipe[s-1];
        l_pipe[s] <= l_pipe[s-1];
      end
    end
  end

  for (genvar c = 0; c < NUM_OC; c++) begin : g_lane
    conv_mac_lane #(
      .DATA_WIDTH  (DATA_WIDTH),
      .FILTER_SIZE (FILTER_SIZE)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (lane_en),
      .window   (i_window),
      .weights  (i_weights[wt_lsb(c, 0, N, DATA_WIDTH) +: TW]),
      .tree_sum (tree[c])
    );
  end

  // Accumulator next value: load on a first beat, otherwise add (wrap or clamp).
  always_comb begin
    sum_nxt = '0;
    for (int unsigned c = 0; c < NUM_OC; c++) begin
      ext[c] = AW'(tree[c]);
`ifdef CONV_MAC_SAT_EN
      wide[c] = {acc[c][AW-1], acc[c]} + {ext[c][AW-1], ext[c]};
      if (f_pipe[D])
        acc_nxt[c] = ext[c];
      else if (wide[c][AW] != wide[c][AW-1])
        acc_nxt[c] = wide[c][AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
      else
        acc_nxt[c] = wide[c][AW-1:0];
`else
      acc_nxt[c] = f_pipe[D] ? ext[c] : acc[c] + ext[c];
`endif
      sum_nxt[c*AW +: AW] = acc_nxt[c];
    end
  end

  // Accumulate/output stage; a result can be replaced in the same cycle it drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < NUM_OC; c++) acc[c] <= '0;
      o_valid <= 1'b0;
      o_sum   <= '0;
    end else if (!stall) begin
      if (v_pipe[D])
        for (int unsigned c = 0; c < NUM_OC; c++) acc[c] <= acc_nxt[c];
      if (v_pipe[D] && l_pipe[D]) begin
        o_valid <= 1'b1;
        o_sum   <= sum_nxt;
      end else begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_mac_array.sv
// Bench for conv_mac_array: directed frames, results checked by a
// queue-based scoreboard monitor. Second instance (ACCUM_WIDTH=20, one
// channel) exercises accumulator overflow.
module tb_conv_mac_array;

  logic         clk;
  logic         rst_n;
  logic         i_valid, i_first, i_last, o_ready;
  logic         i_ready, o_valid, o_proto_err;
  logic [71:0]  i_window;
  logic [287:0] i_weights;
  logic [127:0] o_sum;

  logic         v1, f1, l1, i_ready1, o_valid1, err1;
  logic [71:0]  win1;
  logic [19:0]  o_sum1;

  int checks = 0;
  int errors = 0;
  int res_cnt = 0;
  int cyc = 0;

  typedef struct {
    logic [127:0] sum;
    int           issue;
    bit           lat;
  } exp_t;
  exp_t sb[$];

  conv_mac_array #(
    .DATA_WIDTH (8), .FILTER_SIZE (3), .NUM_OC (4), .ACCUM_WIDTH (32)
  ) dut (
    .clk (clk), .rst_n (rst_n), .i_valid (i_valid), .i_ready (i_ready),
    .i_first (i_first), .i_last (i_last), .i_window (i_window),
    .i_weights (i_weights), .o_valid (o_valid), .o_ready (o_ready),
    .o_sum (o_sum), .o_proto_err (o_proto_err)
  );

  conv_mac_array #(
    .DATA_WIDTH (8), .FILTER_SIZE (3), .NUM_OC (1), .ACCUM_WIDTH (20)
  ) dut_ovf (
    .clk (clk), .rst_n (rst_n), .i_valid (v1), .i_ready (i_ready1),
    .i_first (f1), .i_last (l1), .i_window (win1),
    .i_weights (win1), .o_valid (o_valid1), .o_ready (1'b1),
    .o_sum (o_sum1), .o_proto_err (err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [71:0] win_all(input int v);
    logic [71:0] r;
    for (int j = 0; j < 9; j++) r[j*8 +: 8] = 8'(v);
    return r;
  endfunction

  function automatic logic [287:0] wts(input int base, input bit ramp);
    logic [287:0] r;
    for (int c = 0; c < 4; c++)
      for (int j = 0; j < 9; j++)
        r[(c*9+j)*8 +: 8] = 8'(ramp ? base * (c + 1) : base);
    return r;
  endfunction

  function automatic logic [127:0] sums(input int base, input bit ramp);
    logic [127:0] r;
    for (int c = 0; c < 4; c++) r[c*32 +: 32] = 32'(ramp ? base * (c + 1) : base);
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [71:0] w, input logic [287:0] k, input logic f,
                      input logic l, input bit push, input logic [127:0] e, input bit lat);
    bit ok;
    int issue;
    exp_t x;
    ok = 0;
    issue = 0;
    i_valid = 1'b1; i_first = f; i_last = l; i_window = w; i_weights = k;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      ok = i_ready;
      issue = cyc;
      @(posedge clk);
      #1;
    end
    i_valid = 1'b0; i_first = 1'b0; i_last = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout got=0 want=1");
    end else if (push) begin
      x.sum = e; x.issue = issue; x.lat = lat;
      sb.push_back(x);
    end
  endtask

  task automatic wait_res(input int n);
    for (int t = 0; t < 300 && res_cnt < n; t++) @(negedge clk);
    if (res_cnt < n) begin
      checks++; errors++;
      $display("FAIL result_timeout got=%0d want=%0d", res_cnt, n);
    end
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every transferred result must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && o_valid && o_ready) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result got=%h want=none", o_sum);
        end else begin
          e = sb.pop_front();
          chk("result_sum", o_sum, e.sum);
          if (e.lat) chk("latency", 128'(cyc - e.issue), 128'(6));
        end
        res_cnt++;
      end
    end
  end

  initial begin
    bit seen;
    logic [19:0] ovf_want;
    rst_n = 1'b0; i_valid = 1'b0; i_first = 1'b0; i_last = 1'b0;
    i_window = '0; i_weights = '0; o_ready = 1'b1;
    v1 = 1'b0; f1 = 1'b0; l1 = 1'b0; win1 = '0;

    repeat (2) @(negedge clk);
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o_sum", o_sum, 0);
    chk("rst_proto_err", o_proto_err, 0);
    align();
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_i_ready", i_ready, 1);
    align();

    // single-beat frame, channel c weights c+1
    send(win_all(1), wts(1, 1), 1, 1, 1, sums(9, 1), 1);
    wait_res(1);
    align();

    // four-beat frame: 4 * 9 * (2 * -3) = -216
    for (int b = 0; b < 4; b++)
      send(win_all(2), wts(-3, 0), b == 0, b == 3, b == 3, sums(-216, 0), 0);
    wait_res(2);
    align();

    // backpressure: A (18) stalls at the output, C (-45) waits behind it
    o_ready = 1'b0;
    send(win_all(1), wts(2, 0), 1, 1, 1, sums(18, 0), 0);
    send(win_all(-1), wts(5, 0), 1, 1, 1, sums(-45, 0), 0);
    seen = 0;
    for (int t = 0; t < 50 && !seen; t++) begin
      @(negedge clk);
      seen = o_valid;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL stall_wait got=0 want=1");
    end
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk("stall_i_ready", i_ready, 0);
      chk("stall_o_valid", o_valid, 1);
      chk("stall_o_sum", o_sum, sums(18, 0));
    end
    align();
    o_ready = 1'b1;
    wait_res(4);
    align();
    send(win_all(3), wts(1, 0), 1, 1, 1, sums(27, 0), 0);
    wait_res(5);
    align();

    // framing: stray beat dropped, mid-frame first restarts (18 + 9)
    send(win_all(1), wts(1, 0), 0, 1, 0, '0, 0);
    repeat (2) @(negedge clk);
    chk("drop_proto_err", o_proto_err, 1);
    align();
    send(win_all(1), wts(1, 0), 1, 0, 0, '0, 0);
    send(win_all(2), wts(1, 0), 1, 0, 0, '0, 0);
    send(win_all(1), wts(1, 0), 0, 1, 1, sums(27, 0), 0);
    wait_res(6);
    align();

    // reset mid-frame
    send(win_all(5), wts(1, 0), 1, 0, 0, '0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_o_valid", o_valid, 0);
    chk("midrst_o_sum", o_sum, 0);
    chk("midrst_proto_err", o_proto_err, 0);
    align();
    rst_n = 1'b1;
    align();
    // FSM must be IDLE: a non-first beat is dropped and flags an error
    send(win_all(3), wts(1, 0), 0, 1, 0, '0, 0);
    repeat (8) @(negedge clk);
    chk("postrst_proto_err", o_proto_err, 1);
    align();
    send(win_all(4), wts(1, 0), 1, 1, 1, sums(36, 0), 0);
    wait_res(7);
    align();

    // overflow: 4 beats of 9*127*127 = 145161 into a 20-bit accumulator
`ifdef CONV_MAC_SAT_EN
    ovf_want = 20'(524287);
`else
    ovf_want = 20'(-467932);
`endif
    win1 = win_all(127);
    for (int b = 0; b < 4; b++) begin
      v1 = 1'b1; f1 = (b == 0); l1 = (b == 3);
      align();
    end
    v1 = 1'b0; f1 = 1'b0; l1 = 1'b0;
    seen = 0;
    for (int t = 0; t < 50 && !seen; t++) begin
      @(negedge clk);
      seen = o_valid1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL ovf_wait got=0 want=1");
    end else begin
      chk("ovf_sum", o_sum1, ovf_want);
    end

    repeat (10) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    chk("result_count", res_cnt, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
